matrix_loader_control: RTL and testbench

//  Front-end writer for the matrix-vector engine: parses a byte stream from the serial receiver,

---
 rtl/matrix_loader_control.sv | 206 ++++++++++++++++++++
 tb/tb_matrix_loader_control.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader_control.sv
// Front-end writer for the matrix-vector engine.
// Parses framed bytes (FE, N, N vector bytes, N*N row-major matrix bytes, EF)
// from the serial receiver. Vector elements go to the vector FIFO and matrix row r
// goes to processor FIFO (r mod NUM_PROC). A one-cycle start pulse is issued once
// the processors are idle.
module matrix_loader_control #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_N      = 8,
  parameter int NUM_PROC   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  busy,
  output logic [3:0]            N,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  push_v,
  output logic [NUM_PROC-1:0]   push_a,
  output logic                  fifo_clr,
  output logic                  start,
  output logic                  ready,
  output logic                  error
);

  localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

  localparam logic [DATA_WIDTH-1:0] SOF_BYTE = DATA_WIDTH'(8'hFE);
  localparam logic [DATA_WIDTH-1:0] EOF_BYTE = DATA_WIDTH'(8'hEF);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN  = DATA_WIDTH'(MAX_N);
  localparam logic [PW-1:0]         LAST_PROC = PW'(NUM_PROC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_N,
    S_LOAD_V,
    S_LOAD_A,
    S_GET_END,
    S_WAIT_IDLE,
    S_ISSUE,
    S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              n_q, n_d;
  logic [3:0]              col_q, col_d;
  logic [3:0]              row_q, row_d;
  logic [PW-1:0]           proc_q, proc_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    push_v_q, push_v_d;
  logic [NUM_PROC-1:0]     push_a_q, push_a_d;
  logic                    fifo_clr_q, fifo_clr_d;
  logic                    start_q, start_d;

  logic [3:0] n_m1;
  logic       last_col;
  logic       last_row;
  logic       len_ok;
  logic       is_sof;
  logic       is_eof;

  assign n_m1     = n_q - 4'd1;
  assign last_col = (col_q == n_m1);
  assign last_row = (row_q == n_m1);
  assign len_ok   = (rx_data != '0) && (rx_data <= MAX_LEN);
  assign is_sof   = (rx_data == SOF_BYTE);
  assign is_eof   = (rx_data == EOF_BYTE);

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      proc_q     <= '0;
      wr_data_q  <= '0;
      push_v_q   <= 1'b0;
      push_a_q   <= '0;
      fifo_clr_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      col_q      <= col_d;
      row_q      <= row_d;
      proc_q     <= proc_d;
      wr_data_q  <= wr_data_d;
      push_v_q   <= push_v_d;
      push_a_q   <= push_a_d;
      fifo_clr_q <= fifo_clr_d;
      start_q    <= start_d;
    end
  end

  // Next-state, counter update and one-cycle strobes for the next cycle.
  // proc tracks row mod NUM_PROC incrementally so no divider is needed.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    col_d      = col_q;
    row_d      = row_q;
    proc_d     = proc_q;
    wr_data_d  = wr_data_q;
    push_v_d   = 1'b0;
    push_a_d   = '0;
    fifo_clr_d = 1'b0;
    start_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && is_sof) begin
          state_d    = S_GET_N;
          fifo_clr_d = 1'b1;
        end
      end

      S_GET_N: begin
        if (rx_valid) begin
          if (len_ok) begin
            n_d     = rx_data[3:0];
            col_d   = '0;
            state_d = S_LOAD_V;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_LOAD_V: begin
        if (rx_valid) begin
          push_v_d  = 1'b1;
          wr_data_d = rx_data;
          if (last_col) begin
            col_d   = '0;
            row_d   = '0;
            proc_d  = '0;
            state_d = S_LOAD_A;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end

      S_LOAD_A: begin
        if (rx_valid) begin
          push_a_d[proc_q] = 1'b1;
          wr_data_d        = rx_data;
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = S_GET_END;
            end else begin
              row_d  = row_q + 4'd1;
              proc_d = (proc_q == LAST_PROC) ? '0 : proc_q + PW'(1);
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end

      S_GET_END: begin
        if (rx_valid) begin
          state_d = is_eof ? S_WAIT_IDLE : S_ERR;
        end
      end

      S_WAIT_IDLE: begin
        // A byte arriving while waiting for the processors is an overrun
        // and takes priority over launching the computation.
        if (rx_valid) begin
          state_d = S_ERR;
        end else if (!busy) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
        end
      end

      S_ISSUE: begin
        state_d = S_IDLE;
      end

      S_ERR: begin
        if (rx_valid && is_sof) begin
          state_d    = S_GET_N;
          fifo_clr_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign N        = n_q;
  assign wr_data  = wr_data_q;
  assign push_v   = push_v_q;
  assign push_a   = push_a_q;
  assign fifo_clr = fifo_clr_q;
  assign start    = start_q;
  assign ready    = (state_q == S_IDLE);
  assign error    = (state_q == S_ERR);

endmodule

// File: tb/tb_matrix_loader_control.sv
// Self-checking bench for matrix_loader_control: directed scenarios plus
// randomized frames checked against a frame-level reference of the push stream.
module tb_matrix_loader_control;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            busy;
  logic [3:0]      N;
  logic [7:0]      wr_data;
  logic            push_v;
  logic [NP-1:0]   push_a;
  logic            fifo_clr;
  logic            start;
  logic            ready;
  logic            error;

  int checks   = 0;
  int failures = 0;

  int pv_cnt    = 0;
  int pa_cnt    = 0;
  int excl_err  = 0;
  int start_cnt = 0;

  matrix_loader_control #(
    .DATA_WIDTH (8),
    .MAX_N      (8),
    .NUM_PROC   (NP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .N        (N),
    .wr_data  (wr_data),
    .push_v   (push_v),
    .push_a   (push_a),
    .fifo_clr (fifo_clr),
    .start    (start),
    .ready    (ready),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Observational tallies of strobes on the falling edge.
  always @(negedge clk) begin
    if (push_v) pv_cnt++;
    if (push_a != '0) pa_cnt++;
    if ((push_v && push_a != '0) || !$onehot0(push_a)) excl_err++;
    if (start) start_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Caller sits at a falling edge; the byte is accepted at the next rising edge
  // and its effect is visible when this task returns one falling edge later.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_push(input string tag, input logic pv, input logic [NP-1:0] pa,
                             input logic [7:0] d);
    check({tag, "_pv"}, 32'(push_v), 32'(pv));
    check({tag, "_pa"}, 32'(push_a), 32'(pa));
    if (pv || pa != '0) check({tag, "_data"}, 32'(wr_data), 32'(d));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_N"},        32'(N),        32'd0);
    check({tag, "_wr_data"},  32'(wr_data),  32'd0);
    check({tag, "_push_v"},   32'(push_v),   32'd0);
    check({tag, "_push_a"},   32'(push_a),   32'd0);
    check({tag, "_fifo_clr"}, 32'(fifo_clr), 32'd0);
    check({tag, "_start"},    32'(start),    32'd0);
    check({tag, "_ready"},    32'(ready),    32'd1);
    check({tag, "_error"},    32'(error),    32'd0);
  endtask

  task automatic make_pay(input int n, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n + n * n; i++) q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: FE clears FIFOs; N produces nothing; the first n payload bytes are
  // vector pushes; matrix byte k belongs to row k/n and goes to processor row%NP.
  task automatic load_frame(input int n, input logic [7:0] pay[$]);
    logic [NP-1:0] oh;
    send(8'hFE);
    check("sof_clr", 32'(fifo_clr), 32'd1);
    expect_push("sof", 1'b0, '0, 8'h00);
    send(8'(n));
    expect_push("len", 1'b0, '0, 8'h00);
    check("len_clr", 32'(fifo_clr), 32'd0);
    for (int k = 0; k < n + n * n; k++) begin
      send(pay[k]);
      if (k < n) begin
        expect_push("vec", 1'b1, '0, pay[k]);
      end else begin
        oh = '0;
        oh[((k - n) / n) % NP] = 1'b1;
        expect_push("mat", 1'b0, oh, pay[k]);
      end
    end
    check("n_out", 32'(N), 32'(n));
  endtask

  // Sends the terminator, holds busy for busy_cycles, then expects one start pulse
  // two cycles after the terminator (or right after busy drops).
  task automatic finish_ok(input int busy_cycles);
    busy = (busy_cycles > 0);
    send(8'hEF);
    expect_push("eof", 1'b0, '0, 8'h00);
    check("eof_start", 32'(start), 32'd0);
    check("eof_ready", 32'(ready), 32'd0);
    for (int i = 0; i < busy_cycles; i++) begin
      @(negedge clk);
      check("busy_hold_start", 32'(start), 32'd0);
    end
    busy = 1'b0;
    @(negedge clk);
    check("start_pulse", 32'(start), 32'd1);
    check("start_ready", 32'(ready), 32'd0);
    @(negedge clk);
    check("start_end", 32'(start), 32'd0);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_error", 32'(error), 32'd0);
  endtask

  initial begin
    logic [7:0] pay[$];
    int b_pv, b_pa, b_st;
    int n, bc;

    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    busy     = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready0", 32'(ready), 32'd1);

    // Directed N=2 frame.
    b_pv = pv_cnt; b_pa = pa_cnt; b_st = start_cnt;
    pay = '{8'h05, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04};
    load_frame(2, pay);
    finish_ok(0);
    check("n2_N", 32'(N), 32'd2);
    check("n2_vcount", 32'(pv_cnt - b_pv), 32'd2);
    check("n2_acount", 32'(pa_cnt - b_pa), 32'd4);
    check("n2_starts", 32'(start_cnt - b_st), 32'd1);

    // Full-size N=8 frame.
    b_pv = pv_cnt; b_pa = pa_cnt; b_st = start_cnt;
    make_pay(8, pay);
    load_frame(8, pay);
    finish_ok(0);
    check("n8_vcount", 32'(pv_cnt - b_pv), 32'd8);
    check("n8_acount", 32'(pa_cnt - b_pa), 32'd64);
    check("n8_starts", 32'(start_cnt - b_st), 32'd1);

    // Randomized frames with random processor busy time.
    for (int f = 0; f < 8; f++) begin
      n  = $urandom_range(1, 8);
      bc = $urandom_range(0, 4);
      b_pv = pv_cnt; b_pa = pa_cnt; b_st = start_cnt;
      make_pay(n, pay);
      load_frame(n, pay);
      finish_ok(bc);
      check("rnd_vcount", 32'(pv_cnt - b_pv), 32'(n));
      check("rnd_acount", 32'(pa_cnt - b_pa), 32'(n * n));
      check("rnd_starts", 32'(start_cnt - b_st), 32'd1);
    end

    // Out-of-range lengths, then recovery with FE 01 07 03 EF.
    b_pv = pv_cnt; b_pa = pa_cnt; b_st = start_cnt;
    send(8'hFE);
    send(8'h00);
    check("len0_error", 32'(error), 32'd1);
    check("len0_ready", 32'(ready), 32'd0);
    send(8'hFE);
    check("err_sof_clr", 32'(fifo_clr), 32'd1);
    check("err_sof_error", 32'(error), 32'd0);
    send(8'h09);
    check("len9_error", 32'(error), 32'd1);
    repeat (4) @(negedge clk);
    check("badlen_pushes", 32'(pv_cnt - b_pv + pa_cnt - b_pa), 32'd0);
    check("badlen_starts", 32'(start_cnt - b_st), 32'd0);
    check("badlen_error_hold", 32'(error), 32'd1);
    pay = '{8'h07, 8'h03};
    load_frame(1, pay);
    finish_ok(0);
    check("recover_starts", 32'(start_cnt - b_st), 32'd1);

    // Wrong terminator.
    b_st = start_cnt;
    make_pay(2, pay);
    load_frame(2, pay);
    send(8'hEE);
    check("badeof_error", 32'(error), 32'd1);
    check("badeof_ready", 32'(ready), 32'd0);
    repeat (5) @(negedge clk);
    check("badeof_starts", 32'(start_cnt - b_st), 32'd0);
    make_pay(1, pay);
    load_frame(1, pay);
    check("badeof_ready_mid", 32'(ready), 32'd0);
    finish_ok(0);

    // Processors busy for 10 cycles after the terminator.
    b_st = start_cnt;
    make_pay(3, pay);
    load_frame(3, pay);
    finish_ok(10);
    check("busy10_starts", 32'(start_cnt - b_st), 32'd1);

    // Byte arriving while waiting for the processors.
    b_st = start_cnt;
    make_pay(2, pay);
    load_frame(2, pay);
    busy = 1'b1;
    send(8'hEF);
    check("ovr_wait_ready", 32'(ready), 32'd0);
    send(8'h55);
    expect_push("ovr", 1'b0, '0, 8'h00);
    check("ovr_error", 32'(error), 32'd1);
    busy = 1'b0;
    repeat (5) @(negedge clk);
    check("ovr_starts", 32'(start_cnt - b_st), 32'd0);
    check("ovr_error_hold", 32'(error), 32'd1);
    make_pay(1, pay);
    load_frame(1, pay);
    finish_ok(0);

    // Reset in the middle of matrix loading.
    send(8'hFE);
    send(8'h03);
    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i));
    check("mid_push_a", 32'(push_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    b_pv = pv_cnt; b_pa = pa_cnt; b_st = start_cnt;
    make_pay(2, pay);
    load_frame(2, pay);
    finish_ok(1);
    check("post_rst_vcount", 32'(pv_cnt - b_pv), 32'd2);
    check("post_rst_acount", 32'(pa_cnt - b_pa), 32'd4);
    check("post_rst_starts", 32'(start_cnt - b_st), 32'd1);

    check("push_exclusive", 32'(excl_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
